lcd_vbuf_scanout: RTL and testbench



---
 rtl/ppu_pkg.sv | 40 ++++
 rtl/nes_palette_rgb.sv | 80 ++++++++
 rtl/lcd_vbuf_scanout.sv | 138 +++++++++++++
 tb/tb_lcd_vbuf_scanout.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ppu_pkg
// Brief    : Shared NES frame, video-buffer and default LCD timing constants.
// Revision : 1.0
//==============================================================================
package ppu_pkg;

    localparam int c_NES_W       = 256;
    localparam int c_NES_H       = 240;
    localparam int c_BUF_SEL_BIT = 16;
    localparam int c_RADDR_W     = c_BUF_SEL_BIT + 1;

    localparam int c_H_SYNC = 48;
    localparam int c_H_BP   = 88;
    localparam int c_H_ACT  = 800;
    localparam int c_H_FP   = 40;
    localparam int c_V_SYNC = 3;
    localparam int c_V_BP   = 32;
    localparam int c_V_ACT  = 480;
    localparam int c_V_FP   = 10;
    localparam int c_X_OFF  = 144;
    localparam int c_RD_LAT = 2;

    // Sync flags are stored active-high so a cleared stage means "idle".
    typedef struct packed {
        logic hs_act;
        logic vs_act;
        logic de;
        logic win;
    } ctl_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/nes_palette_rgb.sv
`default_nettype none
//==============================================================================
// Module   : nes_palette_rgb
// Brief    : Combinational 2C02 palette lookup, 6-bit index to RGB888.
// Revision : 1.0
//==============================================================================
module nes_palette_rgb
    import ppu_pkg::*;
(
    input  logic [5:0] i_idx,
    output rgb_t       o_rgb
);

    logic [23:0] w_rgb;

    always_comb begin
        w_rgb = 24'h000000;
        case (i_idx)
            6'h00: w_rgb = 24'h7C7C7C;
            6'h01: w_rgb = 24'h0000FC;
            6'h02: w_rgb = 24'h0000BC;
            6'h03: w_rgb = 24'h4428BC;
            6'h04: w_rgb = 24'h940084;
            6'h05: w_rgb = 24'hA80020;
            6'h06: w_rgb = 24'hA81000;
            6'h07: w_rgb = 24'h881400;
            6'h08: w_rgb = 24'h503000;
            6'h09: w_rgb = 24'h007800;
            6'h0A: w_rgb = 24'h006800;
            6'h0B: w_rgb = 24'h005800;
            6'h0C: w_rgb = 24'h004058;
            6'h10: w_rgb = 24'hBCBCBC;
            6'h11: w_rgb = 24'h0078F8;
            6'h12: w_rgb = 24'h0058F8;
            6'h13: w_rgb = 24'h6844FC;
            6'h14: w_rgb = 24'hD800CC;
            6'h15: w_rgb = 24'hE40058;
            6'h16: w_rgb = 24'hF83800;
            6'h17: w_rgb = 24'hE45C10;
            6'h18: w_rgb = 24'hAC7C00;
            6'h19: w_rgb = 24'h00B800;
            6'h1A: w_rgb = 24'h00A800;
            6'h1B: w_rgb = 24'h00A844;
            6'h1C: w_rgb = 24'h008888;
            6'h20: w_rgb = 24'hF8F8F8;
            6'h21: w_rgb = 24'h3CBCFC;
            6'h22: w_rgb = 24'h6888FC;
            6'h23: w_rgb = 24'h9878F8;
            6'h24: w_rgb = 24'hF878F8;
            6'h25: w_rgb = 24'hF85898;
            6'h26: w_rgb = 24'hF87858;
            6'h27: w_rgb = 24'hFCA044;
            6'h28: w_rgb = 24'hF8B800;
            6'h29: w_rgb = 24'hB8F818;
            6'h2A: w_rgb = 24'h58D854;
            6'h2B: w_rgb = 24'h58F898;
            6'h2C: w_rgb = 24'h00E8D8;
            6'h2D: w_rgb = 24'h787878;
            6'h30: w_rgb = 24'hFCFCFC;
            6'h31: w_rgb = 24'hA4E4FC;
            6'h32: w_rgb = 24'hB8B8F8;
            6'h33: w_rgb = 24'hD8B8F8;
            6'h34: w_rgb = 24'hF8B8F8;
            6'h35: w_rgb = 24'hF8A4C0;
            6'h36: w_rgb = 24'hF0D0B0;
            6'h37: w_rgb = 24'hFCE0A8;
            6'h38: w_rgb = 24'hF8D878;
            6'h39: w_rgb = 24'hD8F878;
            6'h3A: w_rgb = 24'hB8F8B8;
            6'h3B: w_rgb = 24'hB8F8D8;
            6'h3C: w_rgb = 24'h00FCFC;
            6'h3D: w_rgb = 24'hF8D8F8;
            default: w_rgb = 24'h000000;
        endcase
    end

    assign o_rgb = w_rgb;

endmodule
`default_nettype wire

// File: rtl/lcd_vbuf_scanout.sv
`default_nettype none
//==============================================================================
// Module   : lcd_vbuf_scanout
// Brief    : LCD raster timing, 2x-scaled video-buffer scan-out and palette RGB.
// Revision : 1.0
//==============================================================================
module lcd_vbuf_scanout
    import ppu_pkg::*;
#(
    parameter int H_SYNC = c_H_SYNC,
    parameter int H_BP   = c_H_BP,
    parameter int H_ACT  = c_H_ACT,
    parameter int H_FP   = c_H_FP,
    parameter int V_SYNC = c_V_SYNC,
    parameter int V_BP   = c_V_BP,
    parameter int V_ACT  = c_V_ACT,
    parameter int V_FP   = c_V_FP,
    parameter int X_OFF  = c_X_OFF,
    parameter int RD_LAT = c_RD_LAT
) (
    input  logic                 i_lcd_clk,
    input  logic                 i_rstn,
    input  logic                 i_wr_buf,
    output logic [c_RADDR_W-1:0] o_raddr,
    input  logic [7:0]           i_rdata,
    output logic                 o_lcd_hs,
    output logic                 o_lcd_vs,
    output logic                 o_lcd_de,
    output logic [7:0]           o_lcd_r,
    output logic [7:0]           o_lcd_g,
    output logic [7:0]           o_lcd_b
);

    localparam int c_H_TOTAL  = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int c_V_TOTAL  = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int c_HA_START = H_SYNC + H_BP;
    localparam int c_VA_START = V_SYNC + V_BP;
    localparam int c_WIN_W    = 2 * c_NES_W;
    localparam int c_HW       = $clog2(c_H_TOTAL);
    localparam int c_VW       = $clog2(c_V_TOTAL);

    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic            r_rd_buf;
    logic [15:0]     w_hpos;
    logic [15:0]     w_vpos;
    logic [15:0]     w_ax;
    logic [15:0]     w_ay;
    logic [7:0]      w_x;
    logic [7:0]      w_y;
    logic [5:0]      w_idx;
    ctl_t            w_ctl;
    ctl_t            w_ctl_out;
    ctl_t [RD_LAT:0] r_pipe;
    rgb_t            w_pal;

    always_ff @(posedge i_lcd_clk) begin
        if (!i_rstn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == c_HW'(c_H_TOTAL - 1)) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == c_VW'(c_V_TOTAL - 1)) ? '0 : r_vcnt + c_VW'(1);
        end else begin
            r_hcnt <= r_hcnt + c_HW'(1);
        end
    end

    assign w_hpos = 16'(r_hcnt);
    assign w_vpos = 16'(r_vcnt);
    assign w_ax   = w_hpos - 16'(c_HA_START);
    assign w_ay   = w_vpos - 16'(c_VA_START);
    assign w_x    = 8'((w_ax - 16'(X_OFF)) >> 1);
    assign w_y    = 8'(w_ay >> 1);

    always_comb begin
        w_ctl        = '0;
        w_ctl.hs_act = (w_hpos < 16'(H_SYNC));
        w_ctl.vs_act = (w_vpos < 16'(V_SYNC));
        w_ctl.de     = (w_hpos >= 16'(c_HA_START)) && (w_hpos < 16'(c_HA_START + H_ACT)) &&
                       (w_vpos >= 16'(c_VA_START)) && (w_vpos < 16'(c_VA_START + V_ACT));
        w_ctl.win    = w_ctl.de && (w_ax >= 16'(X_OFF)) && (w_ax < 16'(X_OFF + c_WIN_W));
    end

    // Buffer select only changes at the very first clock of a frame, so a
    // PPU swap can never tear the picture being scanned out.
    always_ff @(posedge i_lcd_clk) begin
        if (!i_rstn) begin
            r_rd_buf <= 1'b0;
        end else if ((r_hcnt == '0) && (r_vcnt == '0)) begin
            r_rd_buf <= ~i_wr_buf;
        end
    end

    always_ff @(posedge i_lcd_clk) begin
        if (!i_rstn) begin
            o_raddr <= '0;
        end else if (w_ctl.win) begin
            o_raddr <= {r_rd_buf, w_y, w_x};
        end
    end

    // Stage 0 tracks the address register, stages 1..RD_LAT the RAM latency.
    always_ff @(posedge i_lcd_clk) begin
        if (!i_rstn) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_ctl;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_ctl_out = r_pipe[RD_LAT];
    assign w_idx     = 6'(i_rdata);

    nes_palette_rgb u_palette (
        .i_idx (w_idx),
        .o_rgb (w_pal)
    );

    always_ff @(posedge i_lcd_clk) begin
        if (!i_rstn) begin
            o_lcd_hs                     <= 1'b1;
            o_lcd_vs                     <= 1'b1;
            o_lcd_de                     <= 1'b0;
            {o_lcd_r, o_lcd_g, o_lcd_b}  <= '0;
        end else begin
            o_lcd_hs                     <= ~w_ctl_out.hs_act;
            o_lcd_vs                     <= ~w_ctl_out.vs_act;
            o_lcd_de                     <= w_ctl_out.de;
            {o_lcd_r, o_lcd_g, o_lcd_b}  <= w_ctl_out.win ? w_pal : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_vbuf_scanout.sv
`default_nettype none
//==============================================================================
// Module   : tb_lcd_vbuf_scanout
// Brief    : Directed bench for lcd_vbuf_scanout on a shrunken raster, with
//            RD_LAT = 2, 1 and 3 instances sharing clock, reset and i_wr_buf.
// Revision : 1.0
//==============================================================================
module tb_lcd_vbuf_scanout;

    localparam int T_HS   = 4;
    localparam int T_HBP  = 6;
    localparam int T_HACT = 520;
    localparam int T_HFP  = 6;
    localparam int T_VS   = 2;
    localparam int T_VBP  = 2;
    localparam int T_VACT = 8;
    localparam int T_VFP  = 2;
    localparam int T_XOFF = 4;
    localparam int HT     = T_HS + T_HBP + T_HACT + T_HFP;   // 536
    localparam int VT     = T_VS + T_VBP + T_VACT + T_VFP;   // 14
    localparam int F      = HT * VT;                         // 7504
    localparam int HA0    = T_HS + T_HBP;                    // 10
    localparam int VA0    = T_VS + T_VBP;                    // 4
    localparam int L      = 4;                               // main instance pin latency

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              wr_buf;
    logic [2:0][16:0]  w_raddr;
    logic [2:0][7:0]   w_rdata;
    logic [2:0]        w_hs;
    logic [2:0]        w_vs;
    logic [2:0]        w_de;
    logic [2:0][23:0]  w_rgb;
    logic [16:0]       mq [3][3];

    int k;
    int checks;
    int errors;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    lcd_vbuf_scanout #(.H_SYNC(T_HS), .H_BP(T_HBP), .H_ACT(T_HACT), .H_FP(T_HFP),
                       .V_SYNC(T_VS), .V_BP(T_VBP), .V_ACT(T_VACT), .V_FP(T_VFP),
                       .X_OFF(T_XOFF), .RD_LAT(2)) dut (
        .i_lcd_clk (clk), .i_rstn (rstn), .i_wr_buf (wr_buf),
        .o_raddr (w_raddr[0]), .i_rdata (w_rdata[0]),
        .o_lcd_hs (w_hs[0]), .o_lcd_vs (w_vs[0]), .o_lcd_de (w_de[0]),
        .o_lcd_r (w_rgb[0][23:16]), .o_lcd_g (w_rgb[0][15:8]), .o_lcd_b (w_rgb[0][7:0])
    );

    lcd_vbuf_scanout #(.H_SYNC(T_HS), .H_BP(T_HBP), .H_ACT(T_HACT), .H_FP(T_HFP),
                       .V_SYNC(T_VS), .V_BP(T_VBP), .V_ACT(T_VACT), .V_FP(T_VFP),
                       .X_OFF(T_XOFF), .RD_LAT(1)) dut_l1 (
        .i_lcd_clk (clk), .i_rstn (rstn), .i_wr_buf (wr_buf),
        .o_raddr (w_raddr[1]), .i_rdata (w_rdata[1]),
        .o_lcd_hs (w_hs[1]), .o_lcd_vs (w_vs[1]), .o_lcd_de (w_de[1]),
        .o_lcd_r (w_rgb[1][23:16]), .o_lcd_g (w_rgb[1][15:8]), .o_lcd_b (w_rgb[1][7:0])
    );

    lcd_vbuf_scanout #(.H_SYNC(T_HS), .H_BP(T_HBP), .H_ACT(T_HACT), .H_FP(T_HFP),
                       .V_SYNC(T_VS), .V_BP(T_VBP), .V_ACT(T_VACT), .V_FP(T_VFP),
                       .X_OFF(T_XOFF), .RD_LAT(3)) dut_l3 (
        .i_lcd_clk (clk), .i_rstn (rstn), .i_wr_buf (wr_buf),
        .o_raddr (w_raddr[2]), .i_rdata (w_rdata[2]),
        .o_lcd_hs (w_hs[2]), .o_lcd_vs (w_vs[2]), .o_lcd_de (w_de[2]),
        .o_lcd_r (w_rgb[2][23:16]), .o_lcd_g (w_rgb[2][15:8]), .o_lcd_b (w_rgb[2][7:0])
    );

    // Buffer model: data = x[5:0] with the ignored upper bits set to ones.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mq[d][0] <= w_raddr[d];
            mq[d][1] <= mq[d][0];
            mq[d][2] <= mq[d][1];
        end
    end
    assign w_rdata[0] = {2'b11, mq[0][1][5:0]};
    assign w_rdata[1] = {2'b11, mq[1][0][5:0]};
    assign w_rdata[2] = {2'b11, mq[2][2][5:0]};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k = k + 1;
    endtask

    task automatic goto_k(input int target);
        if (k > target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL goto: at k=%0d, required target k=%0d already passed", k, target);
        end
        while (k < target) step();
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        wr_buf = 1'b0;
        k      = 0;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            checks = checks + 4;
            if (w_hs[d] !== 1'b1) begin errors++; $display("FAIL reset_hs[%0d]: got %b need 1", d, w_hs[d]); end
            if (w_vs[d] !== 1'b1) begin errors++; $display("FAIL reset_vs[%0d]: got %b need 1", d, w_vs[d]); end
            if (w_de[d] !== 1'b0) begin errors++; $display("FAIL reset_de[%0d]: got %b need 0", d, w_de[d]); end
            if (w_rgb[d] !== 24'h0) begin errors++; $display("FAIL reset_rgb[%0d]: got %h need 000000", d, w_rgb[d]); end
        end
        checks = checks + 1;
        if (w_raddr[0] !== 17'h0) begin errors++; $display("FAIL reset_raddr: got %h need 00000", w_raddr[0]); end
        rstn = 1'b1;
        k    = 0;
    endtask

    task automatic test_timing();
        int  hs_low = 0, hs_falls = 0, vs_low = 0, de_hi = 0, de_rises = 0, run = 0, max_run = 0;
        logic prev_hs = 1'b1, prev_de = 1'b0;
        goto_k(L);
        for (int i = 0; i < F; i++) begin
            if (!w_hs[0]) hs_low++;
            if (prev_hs && !w_hs[0]) hs_falls++;
            if (!w_vs[0]) vs_low++;
            if (w_de[0]) begin
                de_hi++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (!prev_de && w_de[0]) de_rises++;
            prev_hs = w_hs[0];
            prev_de = w_de[0];
            step();
        end
        checks = checks + 6;
        if (hs_low != T_HS * VT)     begin errors++; $display("FAIL hs_low_count: got %0d need %0d", hs_low, T_HS * VT); end
        if (hs_falls != VT)          begin errors++; $display("FAIL hs_fall_count: got %0d need %0d", hs_falls, VT); end
        if (vs_low != T_VS * HT)     begin errors++; $display("FAIL vs_low_count: got %0d need %0d", vs_low, T_VS * HT); end
        if (de_hi != T_HACT * T_VACT) begin errors++; $display("FAIL de_high_count: got %0d need %0d", de_hi, T_HACT * T_VACT); end
        if (de_rises != T_VACT)      begin errors++; $display("FAIL de_line_count: got %0d need %0d", de_rises, T_VACT); end
        if (max_run != T_HACT)       begin errors++; $display("FAIL de_run_length: got %0d need %0d", max_run, T_HACT); end
    endtask

    task automatic test_pixels();
        int          ay_t [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7};
        int          ax_t [12] = '{0, 3, 4, 5, 6, 8, 68, 516, 519, 520, 4, 7};
        logic        de_t [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [23:0] rgb_t_ [12] = '{24'h000000, 24'h000000, 24'h7C7C7C, 24'h7C7C7C,
                                     24'h0000FC, 24'h0000BC, 24'hF8F8F8, 24'h000000,
                                     24'h000000, 24'h000000, 24'h7C7C7C, 24'h0000FC};
        for (int i = 0; i < 12; i++) begin
            goto_k(F + (VA0 + ay_t[i]) * HT + HA0 + ax_t[i] + L);
            checks = checks + 2;
            if (w_de[0] !== de_t[i]) begin
                errors++;
                $display("FAIL pixel_de ay=%0d ax=%0d: got %b need %b", ay_t[i], ax_t[i], w_de[0], de_t[i]);
            end
            if (w_rgb[0] !== rgb_t_[i]) begin
                errors++;
                $display("FAIL pixel_rgb ay=%0d ax=%0d: got %h need %h", ay_t[i], ax_t[i], w_rgb[0], rgb_t_[i]);
            end
        end
    endtask

    task automatic test_addr();
        int          ay_t [8] = '{0, 0, 0, 0, 1, 2, 3, 7};
        int          ax_t [8] = '{4, 5, 6, 516, 0, 100, 100, 515};
        logic [16:0] ad_t [8] = '{17'h10000, 17'h10000, 17'h10001, 17'h100FF,
                                  17'h100FF, 17'h10130, 17'h10130, 17'h103FF};
        for (int i = 0; i < 8; i++) begin
            goto_k(2 * F + (VA0 + ay_t[i]) * HT + HA0 + ax_t[i] + 1);
            checks = checks + 1;
            if (w_raddr[0] !== ad_t[i]) begin
                errors++;
                $display("FAIL raddr ay=%0d ax=%0d: got %h need %h", ay_t[i], ax_t[i], w_raddr[0], ad_t[i]);
            end
        end
    endtask

    task automatic test_buf_swap();
        goto_k(3 * F + (VA0 + 2) * HT + HA0 + 1);
        wr_buf = 1'b1;
        goto_k(3 * F + (VA0 + 5) * HT + HA0 + 4 + 1);
        checks = checks + 1;
        if (w_raddr[0] !== 17'h10200) begin errors++; $display("FAIL swap_same_frame: got %h need 10200", w_raddr[0]); end
        goto_k(4 * F + VA0 * HT + HA0 + 6 + 1);
        checks = checks + 1;
        if (w_raddr[0] !== 17'h00001) begin errors++; $display("FAIL swap_next_frame: got %h need 00001", w_raddr[0]); end
        goto_k(4 * F + (VA0 + 3) * HT + HA0 + 1);
        wr_buf = 1'b0;
        goto_k(4 * F + (VA0 + 7) * HT + HA0 + 515 + 1);
        checks = checks + 1;
        if (w_raddr[0] !== 17'h003FF) begin errors++; $display("FAIL swap_back_held: got %h need 003FF", w_raddr[0]); end
        goto_k(5 * F + VA0 * HT + HA0 + 6 + 1);
        checks = checks + 1;
        if (w_raddr[0] !== 17'h10001) begin errors++; $display("FAIL swap_back_frame: got %h need 10001", w_raddr[0]); end
    endtask

    task automatic test_latency();
        int   base = 6 * F;
        int   vs_f [3] = '{-1, -1, -1};
        int   hs_f [3] = '{-1, -1, -1};
        int   de_r [3] = '{-1, -1, -1};
        int   rgb_f [3] = '{-1, -1, -1};
        logic [2:0] p_hs, p_vs, p_de;
        goto_k(base);
        p_hs = w_hs;
        p_vs = w_vs;
        p_de = w_de;
        for (int i = 1; i <= 5 * HT; i++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (p_vs[d] && !w_vs[d] && vs_f[d] < 0) vs_f[d] = k;
                if (p_hs[d] && !w_hs[d] && de_r[d] < 0) hs_f[d] = k;
                if (!p_de[d] && w_de[d] && de_r[d] < 0) de_r[d] = k;
                if (w_de[d] && (w_rgb[d] != 24'h0) && rgb_f[d] < 0) rgb_f[d] = k;
            end
            p_hs = w_hs;
            p_vs = w_vs;
            p_de = w_de;
        end
        for (int d = 0; d < 3; d++) begin
            int lat = lat_of(d) + 2;
            checks = checks + 4;
            if (vs_f[d] != base + lat) begin
                errors++; $display("FAIL lat_vs_fall[rd_lat=%0d]: got k=%0d need k=%0d", lat_of(d), vs_f[d], base + lat);
            end
            if (hs_f[d] != base + VA0 * HT + lat) begin
                errors++; $display("FAIL lat_hs_fall[rd_lat=%0d]: got k=%0d need k=%0d", lat_of(d), hs_f[d], base + VA0 * HT + lat);
            end
            if (de_r[d] - hs_f[d] != HA0) begin
                errors++; $display("FAIL lat_de_vs_hs[rd_lat=%0d]: got %0d need %0d", lat_of(d), de_r[d] - hs_f[d], HA0);
            end
            if (rgb_f[d] - de_r[d] != T_XOFF) begin
                errors++; $display("FAIL lat_rgb_vs_de[rd_lat=%0d]: got %0d need %0d", lat_of(d), rgb_f[d] - de_r[d], T_XOFF);
            end
        end
    endtask

    task automatic test_reset_midline();
        int first [3] = '{-1, -1, -1};
        goto_k(7 * F + VA0 * HT + HA0 + 6 + L);
        checks = checks + 2;
        if (w_de[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_de: got %b need 1", w_de[0]); end
        if (w_rgb[0] !== 24'h0000FC) begin errors++; $display("FAIL pre_reset_rgb: got %h need 0000FC", w_rgb[0]); end
        rstn = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            checks = checks + 4;
            if (w_hs[d] !== 1'b1) begin errors++; $display("FAIL midreset_hs[%0d]: got %b need 1", d, w_hs[d]); end
            if (w_vs[d] !== 1'b1) begin errors++; $display("FAIL midreset_vs[%0d]: got %b need 1", d, w_vs[d]); end
            if (w_de[d] !== 1'b0) begin errors++; $display("FAIL midreset_de[%0d]: got %b need 0", d, w_de[d]); end
            if (w_rgb[d] !== 24'h0) begin errors++; $display("FAIL midreset_rgb[%0d]: got %h need 000000", d, w_rgb[d]); end
        end
        checks = checks + 1;
        if (w_raddr[0] !== 17'h0) begin errors++; $display("FAIL midreset_raddr: got %h need 00000", w_raddr[0]); end
        rstn = 1'b1;
        k    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (!w_hs[d] && first[d] < 0) first[d] = k;
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks = checks + 1;
            if (first[d] != lat_of(d) + 2) begin
                errors++; $display("FAIL restart_hs_fall[rd_lat=%0d]: got %0d clocks need %0d", lat_of(d), first[d], lat_of(d) + 2);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        k      = 0;
        rstn   = 1'b0;
        wr_buf = 1'b0;
        test_reset();
        test_timing();
        test_pixels();
        test_addr();
        test_buf_swap();
        test_latency();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
